// File: rtl/fetch_pkg.sv
// Shared fetch types and defaults: PC/data widths, reset PC, prefetch depth.
// No logic; imported by the fetch unit and its prefetch FIFO.
package fetch_pkg;

  localparam int FETCH_ADDR_WIDTH = 16;
  localparam int FETCH_DATA_WIDTH = 16;

  localparam logic [FETCH_ADDR_WIDTH-1:0] RESET_PC_DEFAULT    = 16'h0000;
  localparam int                          FETCH_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [FETCH_ADDR_WIDTH-1:0] pc;
    logic [FETCH_DATA_WIDTH-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, data} entries; head is presented combinationally.
// Push/pop take effect at the edge; flush beats push and pop.
// Backpressure: the caller never pushes when full and never pops when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t,
  parameter int  DEPTH   = FETCH_DEPTH_DEFAULT,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output entry_t        head
);

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    mem_q    <= mem_d;
    rd_ptr_q <= rd_ptr_d;
    wr_ptr_q <= wr_ptr_d;
    count_q  <= count_d;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: drives the ROM address, captures the registered ROM word
// one cycle later and queues {pc, data} for the decoder; redirect flushes all.
// Backpressure: issue stops once buffered plus in-flight words reach DEPTH.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = FETCH_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = FETCH_DATA_WIDTH,
  parameter int                    DEPTH      = FETCH_DEPTH_DEFAULT,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] data;
  } if_entry_t;

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  inflight_v_q, inflight_v_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;

  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic          issue;
  logic          flush;
  logic          push;
  logic          pop;
  if_entry_t     push_data;
  if_entry_t     head;

  // Issue ignores a same-cycle pop so the FIFO can never overflow.
  always_comb begin
    occupancy      = {1'b0, count} + (CW + 1)'(inflight_v_q);
    issue          = !redirect && (occupancy < (CW + 1)'(DEPTH));
    flush          = !reset_n || redirect;
    push           = inflight_v_q && !flush;
    pop            = instr_valid && instr_ready && !flush;
    push_data.pc   = inflight_pc_q;
    push_data.data = rom_data;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_v_d  = issue;
    inflight_pc_d = inflight_pc_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + ADDR_WIDTH'(1);
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_v_q  <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_v_q  <= inflight_v_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(
    .entry_t (if_entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  assign rom_addr    = fetch_pc_q;
  assign instr_valid = (count != '0);
  assign instr_data  = instr_valid ? head.data : '0;
  assign instr_pc    = instr_valid ? head.pc : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch with a preloaded synchronous ROM (mem[i] = i ^ 0xA5A5);
// expected words come from a PC-stream model reset by every flush.
module tb_instr_fetch;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, redirect, instr_ready, instr_valid;
  logic [15:0] redirect_pc, rom_addr, rom_data, instr_data, instr_pc;

  logic        reset_n_b, redirect_b, instr_ready_b, instr_valid_b;
  logic [15:0] redirect_pc_b, rom_addr_b, rom_data_b, instr_data_b, instr_pc_b;

  logic [15:0] rom_mem [0:65535];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_pc;
  bit          mon_en = 1'b0;

  instr_fetch #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut_a (
    .clk(clk), .reset_n(reset_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_data(instr_data), .instr_pc(instr_pc), .instr_ready(instr_ready));

  instr_fetch #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(DEPTH), .RESET_PC(16'hFFFE)) dut_b (
    .clk(clk), .reset_n(reset_n_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .redirect(redirect_b), .redirect_pc(redirect_pc_b), .instr_valid(instr_valid_b),
    .instr_data(instr_data_b), .instr_pc(instr_pc_b), .instr_ready(instr_ready_b));

  initial for (int i = 0; i < 65536; i++) rom_mem[i] = 16'(i) ^ 16'hA5A5;

  always @(posedge clk) begin
    rom_data   <= rom_mem[rom_addr];
    rom_data_b <= rom_mem[rom_addr_b];
  end

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (int'(dut_a.u_fifo.count_q) > DEPTH) begin
        errors++;
        $display("FAIL count_bound: count=%0d max=%0d", dut_a.u_fifo.count_q, DEPTH);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    instr_ready = 1'b0;
    tick();
    tick();
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", instr_valid); end
    checks++; if (rom_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", rom_addr); end
    checks++; if (instr_pc !== 16'h0000 || instr_data !== 16'h0000) begin
      errors++; $display("FAIL reset_outs: pc=%h data=%h want 0000/0000", instr_pc, instr_data); end
    reset_n = 1'b1;
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_edge1_valid: got %0b want 0", instr_valid); end
    checks++; if (rom_addr !== 16'h0001) begin errors++; $display("FAIL reset_edge1_addr: got %h want 0001", rom_addr); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || instr_data !== 16'hA5A5) begin
      errors++; $display("FAIL reset_first_word: v=%0b pc=%h data=%h want 1/0000/a5a5", instr_valid, instr_pc, instr_data); end
  endtask

  task automatic test_stream();
    do_reset();
    reset_n     = 1'b1;
    instr_ready = 1'b1;
    exp_pc      = 16'h0000;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      tick();
      checks++; if (instr_valid !== (cyc >= 2)) begin
        errors++; $display("FAIL stream_valid: cyc %0d got %0b want %0b", cyc, instr_valid, cyc >= 2); end
      if (instr_valid) begin
        checks++; if (instr_pc !== exp_pc || instr_data !== (exp_pc ^ 16'hA5A5)) begin
          errors++; $display("FAIL stream_word: pc=%h data=%h want %h/%h", instr_pc, instr_data, exp_pc, exp_pc ^ 16'hA5A5); end
        exp_pc++;
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    reset_n = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      tick();
      if (cyc >= 2) begin
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || instr_data !== 16'hA5A5) begin
          errors++; $display("FAIL bp_hold: v=%0b pc=%h data=%h want 1/0000/a5a5", instr_valid, instr_pc, instr_data); end
      end
    end
    checks++; if (int'(dut_a.u_fifo.count_q) != DEPTH) begin
      errors++; $display("FAIL bp_count: got %0d want %0d", dut_a.u_fifo.count_q, DEPTH); end
    checks++; if (rom_addr !== 16'h0004) begin errors++; $display("FAIL bp_addr: got %h want 0004", rom_addr); end
    instr_ready = 1'b1;
    exp_pc      = 16'h0000;
    for (int k = 0; k < 10; k++) begin
      checks++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_data !== (exp_pc ^ 16'hA5A5)) begin
        errors++; $display("FAIL bp_drain: v=%0b pc=%h data=%h want 1/%h", instr_valid, instr_pc, instr_data, exp_pc); end
      exp_pc++;
      tick();
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    reset_n = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) tick();
    checks++; if (int'(dut_a.u_fifo.count_q) != DEPTH - 1) begin
      errors++; $display("FAIL redir_setup: count=%0d want %0d", dut_a.u_fifo.count_q, DEPTH - 1); end
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    instr_ready = 1'b1;
    tick();
    redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0 || rom_addr !== 16'h0100) begin
      errors++; $display("FAIL redir_flush: v=%0b addr=%h want 0/0100", instr_valid, rom_addr); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_r1: got %0b want 0", instr_valid); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0100 || instr_data !== 16'hA4A5) begin
      errors++; $display("FAIL redir_first: v=%0b pc=%h data=%h want 1/0100/a4a5", instr_valid, instr_pc, instr_data); end
    exp_pc = 16'h0101;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_data !== (exp_pc ^ 16'hA5A5)) begin
        errors++; $display("FAIL redir_stream: v=%0b pc=%h data=%h want 1/%h", instr_valid, instr_pc, instr_data, exp_pc); end
      exp_pc++;
    end
  endtask

  task automatic test_wrap();
    int n;
    n = 0;
    instr_ready_b = 1'b1;
    reset_n_b     = 1'b0;
    tick();
    tick();
    reset_n_b = 1'b1;
    exp_pc    = 16'hFFFE;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      tick();
      checks++; if (instr_valid_b !== (cyc >= 2)) begin
        errors++; $display("FAIL wrap_valid: cyc %0d got %0b want %0b", cyc, instr_valid_b, cyc >= 2); end
      if (instr_valid_b) begin
        checks++; if (instr_pc_b !== exp_pc || instr_data_b !== (exp_pc ^ 16'hA5A5)) begin
          errors++; $display("FAIL wrap_word: pc=%h data=%h want %h/%h", instr_pc_b, instr_data_b, exp_pc, exp_pc ^ 16'hA5A5); end
        exp_pc++;
        n++;
      end
    end
    checks++; if (n != 9) begin errors++; $display("FAIL wrap_count: got %0d want 9", n); end
  endtask

  task automatic test_midreset();
    do_reset();
    reset_n = 1'b1;
    exp_pc  = 16'h0000;
    for (int cyc = 0; cyc < 40; cyc++) begin
      instr_ready = 1'($urandom_range(0, 1));
      if (instr_valid && instr_ready) begin
        checks++; if (instr_pc !== exp_pc || instr_data !== (exp_pc ^ 16'hA5A5)) begin
          errors++; $display("FAIL mid_pre: pc=%h data=%h want %h", instr_pc, instr_data, exp_pc); end
        exp_pc++;
      end
      tick();
    end
    reset_n     = 1'b0;
    instr_ready = 1'($urandom_range(0, 1));
    tick();
    checks++; if (instr_valid !== 1'b0 || rom_addr !== 16'h0000) begin
      errors++; $display("FAIL mid_reset: v=%0b addr=%h want 0/0000", instr_valid, rom_addr); end
    reset_n     = 1'b1;
    instr_ready = 1'($urandom_range(0, 1));
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mid_edge1: got %0b want 0", instr_valid); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0000) begin
      errors++; $display("FAIL mid_first: v=%0b pc=%h want 1/0000", instr_valid, instr_pc); end
    exp_pc = 16'h0000;
    for (int cyc = 0; cyc < 40; cyc++) begin
      instr_ready = 1'($urandom_range(0, 1));
      if (instr_valid && instr_ready) begin
        checks++; if (instr_pc !== exp_pc || instr_data !== (exp_pc ^ 16'hA5A5)) begin
          errors++; $display("FAIL mid_post: pc=%h data=%h want %h", instr_pc, instr_data, exp_pc); end
        exp_pc++;
      end
      tick();
    end
  endtask

  task automatic test_double_redirect();
    do_reset();
    reset_n     = 1'b1;
    instr_ready = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) tick();
    redirect    = 1'b1;
    redirect_pc = 16'h0200;
    tick();
    redirect_pc = 16'h0300;
    tick();
    redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0 || rom_addr !== 16'h0300) begin
      errors++; $display("FAIL dbl_flush: v=%0b addr=%h want 0/0300", instr_valid, rom_addr); end
    exp_pc = 16'h0300;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (instr_valid !== (i >= 1)) begin
        errors++; $display("FAIL dbl_valid: i %0d got %0b want %0b", i, instr_valid, i >= 1); end
      if (instr_valid) begin
        checks++; if (instr_pc !== exp_pc || instr_data !== (exp_pc ^ 16'hA5A5)) begin
          errors++; $display("FAIL dbl_word: pc=%h data=%h want %h", instr_pc, instr_data, exp_pc); end
        exp_pc++;
      end
    end
  endtask

  task automatic test_random_redirect();
    int since;
    logic [15:0] tgt;
    since = -1;
    do_reset();
    reset_n = 1'b1;
    exp_pc  = 16'h0000;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (since >= 0) begin
        checks++; if (instr_valid !== (since == 2)) begin
          errors++; $display("FAIL rnd_latency: since %0d got %0b want %0b", since, instr_valid, since == 2); end
        since = (since >= 2) ? -1 : since + 1;
      end
      instr_ready = 1'($urandom_range(0, 1));
      redirect    = ($urandom_range(0, 7) == 0);
      tgt         = 16'($urandom);
      redirect_pc = tgt;
      if (redirect) begin
        exp_pc = tgt;
      end else if (instr_valid && instr_ready) begin
        checks++; if (instr_pc !== exp_pc || instr_data !== (exp_pc ^ 16'hA5A5)) begin
          errors++; $display("FAIL rnd_word: pc=%h data=%h want %h", instr_pc, instr_data, exp_pc); end
        exp_pc++;
      end
      tick();
      if (redirect) since = 0;
      redirect = 1'b0;
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = 16'h0000;
    instr_ready   = 1'b0;
    reset_n_b     = 1'b0;
    redirect_b    = 1'b0;
    redirect_pc_b = 16'h0000;
    instr_ready_b = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_wrap();
    test_midreset();
    test_double_redirect();
    test_random_redirect();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
